// File: rtl/text_pixel_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | text_pixel_sequencer                                                   |
// | Three-stage text-mode pipeline: text-RAM -> font-ROM -> attribute/fg.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module text_pixel_sequencer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_LOG2   = 4,
  parameter int CURSOR_START = 14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic        i_de,
  input  logic        i_hsync,
  input  logic        i_vsync,
  output logic [11:0] o_vram_addr,
  input  logic [15:0] i_vram_data,
  output logic [11:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  input  logic [11:0] i_cursor_addr,
  input  logic        i_cursor_en,
  input  logic        i_blink_en,
  output logic [7:0]  o_attr,
  output logic        o_fg,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync
);

  localparam int          FW        = BLINK_LOG2 + 1;
  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [11:0] ROWS_W    = 12'(ROWS);
  localparam logic [3:0]  CUR_START = 4'(CURSOR_START);

  // Stage 1
  logic [11:0] vram_addr_q, vram_addr_d;
  logic [2:0]  px1_q, px1_d;
  logic [3:0]  line1_q, line1_d;
  logic        inrange1_q, inrange1_d;
  // Stage 2
  logic [11:0] font_addr_q, font_addr_d;
  logic [7:0]  attr2_q, attr2_d;
  logic        cur_hit_q, cur_hit_d;
  logic [2:0]  px2_q, px2_d;
  logic        inrange2_q, inrange2_d;
  // Stage 3
  logic [7:0]  attr_q, attr_d;
  logic        fg_q, fg_d;
  // Timing delay lines; de_dly also qualifies stages 2 and 3
  logic [2:0]  de_dly_q, de_dly_d;
  logic [2:0]  hs_dly_q, hs_dly_d;
  logic [2:0]  vs_dly_q, vs_dly_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  logic [6:0] col;
  logic [4:0] row;
  logic       pix;
  logic       blink_on;
  logic       vs_rise;

  // Rows beyond 31 alias; the range flag only looks at the 5-bit row index.
  logic unused_y9;
  assign unused_y9 = i_y[9];

  always_comb begin
    col           = i_x[9:3];
    row           = i_y[8:4];
    vram_addr_d   = 12'(row) * COLS_W + 12'(col);
    px1_d         = i_x[2:0];
    line1_d       = i_y[3:0];
    inrange1_d    = ({5'd0, col} < COLS_W) && ({7'd0, row} < ROWS_W);

    font_addr_d   = {i_vram_data[7:0], line1_q};
    attr2_d       = i_vram_data[15:8];
    cur_hit_d     = i_cursor_en && (vram_addr_q == i_cursor_addr) && (line1_q >= CUR_START);
    px2_d         = px1_q;
    inrange2_d    = inrange1_q;

    pix           = i_font_data[3'd7 - px2_q];
    blink_on      = i_blink_en && attr2_q[7];
    attr_d        = 8'd0;
    fg_d          = 1'b0;
    if (de_dly_q[1] && inrange2_q) begin
      attr_d = blink_on ? {1'b0, attr2_q[6:0]} : attr2_q;
      fg_d   = pix;
      if (blink_on && frame_cnt_q[BLINK_LOG2])
        fg_d = 1'b0;
      // Cursor wins over a blink-hidden glyph.
      if (cur_hit_q && !frame_cnt_q[BLINK_LOG2-1])
        fg_d = 1'b1;
    end

    de_dly_d      = {de_dly_q[1:0], i_de};
    hs_dly_d      = {hs_dly_q[1:0], i_hsync};
    vs_dly_d      = {vs_dly_q[1:0], i_vsync};

    vs_rise       = i_vsync && !vsync_prev_q;
    vsync_prev_d  = i_vsync;
    frame_cnt_d   = frame_cnt_q + {{(FW-1){1'b0}}, vs_rise};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vram_addr_q  <= '0;
      px1_q        <= '0;
      line1_q      <= '0;
      inrange1_q   <= 1'b0;
      font_addr_q  <= '0;
      attr2_q      <= '0;
      cur_hit_q    <= 1'b0;
      px2_q        <= '0;
      inrange2_q   <= 1'b0;
      attr_q       <= '0;
      fg_q         <= 1'b0;
      de_dly_q     <= '0;
      hs_dly_q     <= '0;
      vs_dly_q     <= '0;
      vsync_prev_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vram_addr_q  <= vram_addr_d;
      px1_q        <= px1_d;
      line1_q      <= line1_d;
      inrange1_q   <= inrange1_d;
      font_addr_q  <= font_addr_d;
      attr2_q      <= attr2_d;
      cur_hit_q    <= cur_hit_d;
      px2_q        <= px2_d;
      inrange2_q   <= inrange2_d;
      attr_q       <= attr_d;
      fg_q         <= fg_d;
      de_dly_q     <= de_dly_d;
      hs_dly_q     <= hs_dly_d;
      vs_dly_q     <= vs_dly_d;
      vsync_prev_q <= vsync_prev_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign o_vram_addr = vram_addr_q;
  assign o_font_addr = font_addr_q;
  assign o_attr      = attr_q;
  assign o_fg        = fg_q;
  assign o_de        = de_dly_q[2];
  assign o_hsync     = hs_dly_q[2];
  assign o_vsync     = vs_dly_q[2];

endmodule
`default_nettype wire

// File: tb/tb_text_pixel_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_text_pixel_sequencer                                                |
// | Scoreboard bench: memories modelled in the bench, 3-cycle latency.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_text_pixel_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [9:0]  i_x, i_y;
  logic        i_de, i_hsync, i_vsync;
  logic [11:0] o_vram_addr;
  logic [15:0] i_vram_data;
  logic [11:0] o_font_addr;
  logic [7:0]  i_font_data;
  logic [11:0] i_cursor_addr;
  logic        i_cursor_en, i_blink_en;
  logic [7:0]  o_attr;
  logic        o_fg, o_de, o_hsync, o_vsync;

  always #5 i_clk = ~i_clk;

  text_pixel_sequencer #(
    .COLS(80), .ROWS(30), .BLINK_LOG2(4), .CURSOR_START(14)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_de(i_de),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .o_vram_addr(o_vram_addr),
    .i_vram_data(i_vram_data), .o_font_addr(o_font_addr), .i_font_data(i_font_data),
    .i_cursor_addr(i_cursor_addr), .i_cursor_en(i_cursor_en), .i_blink_en(i_blink_en),
    .o_attr(o_attr), .o_fg(o_fg), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync)
  );

  // Text RAM and font ROM answer the address the DUT is presenting.
  logic [15:0] vram [4096];
  logic [7:0]  font [4096];
  assign i_vram_data = vram[o_vram_addr];
  assign i_font_data = font[o_font_addr];

  typedef struct {
    logic [9:0]  x, y;
    logic        de, hs, vs, blink, cur_en;
    logic [11:0] cur_addr;
  } stim_t;

  typedef struct {
    logic [7:0] attr;
    logic       fg, de, hs, vs;
  } exp_t;

  stim_t       sq[$];
  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [4:0]  fc_m;
  logic        prev_vs;
  logic        cfg_blink, cfg_cur_en;
  logic [11:0] cfg_cur_addr;

  function automatic exp_t model(input stim_t s);
    exp_t       r;
    int         col, row;
    logic [11:0] addr;
    logic [15:0] w;
    logic [7:0]  fr;
    logic        bo;
    col    = int'(s.x[9:3]);
    row    = int'(s.y[8:4]);
    addr   = 12'(row * 80 + col);
    r.de   = s.de;
    r.hs   = s.hs;
    r.vs   = s.vs;
    r.attr = 8'h00;
    r.fg   = 1'b0;
    if (s.de && col < 80 && row < 30) begin
      w      = vram[addr];
      fr     = font[{w[7:0], s.y[3:0]}];
      bo     = s.blink && w[15];
      r.attr = bo ? {1'b0, w[14:8]} : w[15:8];
      r.fg   = fr[7 - int'(s.x[2:0])];
      if (bo && fc_m[4]) r.fg = 1'b0;
      if (s.cur_en && addr == s.cur_addr && s.y[3:0] >= 4'd14 && !fc_m[3]) r.fg = 1'b1;
    end
    return r;
  endfunction

  task automatic add_raw(input int x, input int y, input logic de, input logic hs, input logic vs);
    stim_t s;
    s.x = 10'(x); s.y = 10'(y); s.de = de; s.hs = hs; s.vs = vs;
    s.blink = cfg_blink; s.cur_en = cfg_cur_en; s.cur_addr = cfg_cur_addr;
    sq.push_back(s);
  endtask

  task automatic add_px(input int x, input int y);
    add_raw(x, y, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_raw(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Two idle cycles before a vsync rise keep in-flight pixels on the old frame.
  task automatic add_vs(input int n);
    add_idle(2);
    for (int i = 0; i < n; i++) begin
      add_raw(0, 0, 1'b0, 1'b0, 1'b1);
      add_raw(0, 0, 1'b0, 1'b0, 1'b0);
    end
    add_idle(2);
  endtask

  task automatic step(input stim_t s);
    i_x = s.x; i_y = s.y; i_de = s.de; i_hsync = s.hs; i_vsync = s.vs;
    i_blink_en = s.blink; i_cursor_en = s.cur_en; i_cursor_addr = s.cur_addr;
    sb.push_back(model(s));
    if (s.vs && !prev_vs) fc_m = fc_m + 5'd1;
    prev_vs = s.vs;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    vram[245] = 16'h9F42;
    cfg_blink = 1'b1;
    add_vs(16);
    add_px(40, 48);
    add_px(41, 49);
    add_px(42, 50);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL reset_pre[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_vram_addr, o_font_addr, o_attr, o_fg, o_de, o_hsync, o_vsync} !== 36'd0) begin
      n_fail++;
      $display("FAIL async_reset: outputs got %h expected 0",
               {o_vram_addr, o_font_addr, o_attr, o_fg, o_de, o_hsync, o_vsync});
    end
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    sb.delete();
    fc_m = 5'd0;
    prev_vs = 1'b0;
    add_px(40, 48);
    add_px(47, 63);
    add_idle(3);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL reset_post[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_addressing;
    vram[162]   = 16'h1E41;
    font[12'h413] = 8'h80;
    cfg_blink   = 1'b0;
    add_px(17, 35);
    add_idle(2);
    add_px(16, 35);
    add_idle(3);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (i == 0) begin
        n_checks++;
        if (o_vram_addr !== 12'd162) begin
          n_fail++;
          $display("FAIL vram_addr: got %0d expected 162", o_vram_addr);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (o_font_addr !== 12'h413) begin
          n_fail++;
          $display("FAIL font_addr: got %h expected 413", o_font_addr);
        end
      end
      if (i == 2 || i == 5) begin
        n_checks++;
        if ({o_attr, o_fg} !== {8'h1E, (i == 5)}) begin
          n_fail++;
          $display("FAIL latency_px[%0d]: attr/fg got %h/%b expected 1e/%b", i, o_attr, o_fg, (i == 5));
        end
      end
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL addressing[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_blink;
    cfg_blink = 1'b1;
    for (int f = 0; f < 16; f++) begin
      add_px(40 + (f % 8), 48 + f);
      add_vs(1);
    end
    add_px(43, 50);
    add_idle(3);
    cfg_blink = 1'b0;
    add_px(44, 51);
    add_vs(16);
    add_px(45, 52);
    add_idle(3);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL blink[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_cursor;
    vram[162]    = 16'h0700;
    vram[163]    = 16'h8742;
    cfg_blink    = 1'b1;
    cfg_cur_en   = 1'b1;
    cfg_cur_addr = 12'd162;
    add_px(16, 46);
    add_px(16, 45);
    add_px(17, 47);
    add_vs(8);
    add_px(16, 46);
    add_vs(8);
    add_idle(3);
    cfg_cur_addr = 12'd163;
    add_px(24, 46);
    add_px(24, 45);
    add_idle(3);
    cfg_cur_en = 1'b0;
    add_idle(3);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL cursor[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_blanking;
    cfg_blink = 1'b0;
    add_raw(40, 48, 1'b0, 1'b0, 1'b0);
    add_raw(41, 48, 1'b0, 1'b0, 1'b0);
    add_px(40, 48);
    for (int i = 0; i < 3; i++) add_raw(40, 48, 1'b0, 1'b1, 1'b0);
    add_idle(2);
    for (int i = 0; i < 2; i++) add_raw(0, 0, 1'b0, 1'b0, 1'b1);
    add_idle(1);
    add_raw(41, 48, 1'b1, 1'b1, 1'b0);
    add_idle(3);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL blanking[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_out_of_range;
    vram[2402] = 16'h0F42;
    vram[320]  = 16'h0F42;
    vram[2322] = 16'h0F42;
    cfg_blink  = 1'b1;
    add_px(16, 480);
    add_px(640, 48);
    add_px(16, 479);
    add_vs(14);
    add_px(40, 48);
    add_vs(1);
    add_px(40, 48);
    add_idle(3);
    for (int i = 0; i < sq.size(); i++) begin
      step(sq[i]);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        n_checks++;
        if ({o_attr, o_fg, o_de, o_hsync, o_vsync} !== {e.attr, e.fg, e.de, e.hs, e.vs}) begin
          n_fail++;
          $display("FAIL out_of_range[%0d]: {attr,fg,de,hs,vs} got %h expected %h", i,
                   {o_attr, o_fg, o_de, o_hsync, o_vsync}, {e.attr, e.fg, e.de, e.hs, e.vs});
        end
      end
    end
    sq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vram[i] = 16'h0000;
      font[i] = 8'h00;
    end
    for (int l = 0; l < 16; l++) font[{8'h42, 4'(l)}] = 8'hFF;
    cfg_blink = 1'b0; cfg_cur_en = 1'b0; cfg_cur_addr = 12'd0;
    fc_m = 5'd0; prev_vs = 1'b0;
    i_rst = 1'b1;
    i_x = '0; i_y = '0; i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
    i_blink_en = 1'b0; i_cursor_en = 1'b0; i_cursor_addr = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    test_reset();
    test_addressing();
    test_blink();
    test_cursor();
    test_blanking();
    test_out_of_range();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_pixel_sequencer.md
Name: text_pixel_sequencer

Overview:
- Sequences the text-mode pixel pipeline that feeds the CGA colour stage for an 8x16 font.
- Per pixel: issues the text-RAM address for the current character cell, then the font-ROM address for the current scanline.
- Selects the font bit, then drives the colour stage's attribute byte {irgb back, irgb fore} and its foreground-select bit.
- Adds frame-based character blink and a hardware cursor; delays video-timing signals to match pipeline latency.

Parameters:
- COLS, 80, character columns per row.
- ROWS, 30, character rows per screen.
- BLINK_LOG2, 4, character blink toggles every 2^BLINK_LOG2 frames.
- CURSOR_START, 14, first cell scanline (0..15) of the underline cursor; the cursor covers CURSOR_START..15.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_x  in  10  pixel column from the timing generator.
- i_y  in  10  pixel line from the timing generator.
- i_de  in  1  display enable for (i_x, i_y).
- i_hsync  in  1  horizontal sync, aligned with i_x.
- i_vsync  in  1  vertical sync, aligned with i_x; active-high pulse.
- o_vram_addr  out  12  text-RAM word address, row*COLS+col.
- i_vram_data  in  16  {attr[15:8], char[7:0]}; valid 1 cycle after o_vram_addr (synchronous RAM).
- o_font_addr  out  12  {char, scanline[3:0]}.
- i_font_data  in  8  font row, MSB = leftmost pixel; valid 1 cycle after o_font_addr.
- i_cursor_addr  in  12  cursor cell address, same encoding as o_vram_addr.
- i_cursor_en  in  1  cursor enable.
- i_blink_en  in  1  1: attr bit 7 means blink; 0: attr bit 7 is background intensity.
- o_attr  out  8  attribute byte to the colour stage.
- o_fg  out  1  foreground-select bit to the colour stage.
- o_de  out  1  i_de delayed by 3 cycles.
- o_hsync  out  1  i_hsync delayed by 3 cycles.
- o_vsync  out  1  i_vsync delayed by 3 cycles.

Behaviour:
- Reset (async, i_rst=1): every output register is 0, including o_vram_addr, o_font_addr, o_attr, o_fg and the three delayed timing outputs. The frame counter and all pipeline registers are 0. Asserting reset mid-line takes effect immediately and does not wait for a clock edge. Normal operation resumes on the first edge after release.
- Pipeline: fixed latency of 3 cycles, no stalls. Input presented in cycle N produces o_attr/o_fg/o_de/o_hsync/o_vsync at edge N+3.
- Edge 1:
  - col = i_x[9:3], row = i_y[8:4].
  - o_vram_addr <= row*COLS + col, computed as an unsigned 12-bit product; no wrap is expected within range.
  - Register i_x[2:0], i_y[3:0], i_de, and the flag inrange = (col<COLS && row<ROWS).
- Edge 2:
  - o_font_addr <= {i_vram_data[7:0], line_d1}.
  - attr_d2 <= i_vram_data[15:8].
  - cur_hit <= i_cursor_en && (o_vram_addr==i_cursor_addr) && (line_d1>=CURSOR_START).
  - Delay pixel index, de and inrange one more stage.
- Edge 3:
  - pix = i_font_data[7 - px_d2].
  - If !de_d2 or !inrange_d2: o_attr <= 0 and o_fg <= 0.
  - Otherwise blink_on = i_blink_en && attr_d2[7].
  - o_attr <= blink_on ? {1'b0, attr_d2[6:0]} : attr_d2.
  - fg = pix, then forced to 0 if blink_on && frame_cnt[BLINK_LOG2]==1.
  - fg is then forced to 1 if cur_hit && frame_cnt[BLINK_LOG2-1]==0. The cursor overrides blink.
- Frame counter:
  - Width BLINK_LOG2+1. i_vsync is registered once for edge detection.
  - Increments by 1 on each detected 0->1 transition of i_vsync and wraps naturally at 2^(BLINK_LOG2+1).
  - Consequence: the cursor blinks at twice the character-blink rate.
- Timing delays: o_de, o_hsync and o_vsync are pure 3-stage shift registers and are unaffected by the inrange flag.
- Boundary rows: lines past ROWS*16 with i_de=1 output black (o_attr=0, o_fg=0). The address is still issued; its value is don't-care.

Test Plan:
- Reset: assert i_rst asynchronously mid-line with the pipeline full -> all outputs 0 before the next i_clk edge; frame counter 0 after release.
- Addressing and latency: i_x=17, i_y=35, i_de=1 at cycle 0.
  - Edge 1: o_vram_addr=162.
  - Return i_vram_data=16'h1E41 -> edge 2: o_font_addr=12'h413.
  - Return i_font_data=8'h80 -> edge 3: o_attr=8'h1E, o_fg=0, since px=1 selects bit 6.
  - Repeat with i_x=16 -> o_fg=1.
- Blink: attr 8'h9F, font 8'hFF, i_blink_en=1.
  - Frames 0..15: o_attr=8'h1F, o_fg=1.
  - After 16 i_vsync rising edges: o_fg=0.
  - With i_blink_en=0: o_attr=8'h9F, o_fg=1 in all frames.
- Cursor: i_cursor_addr=162, i_cursor_en=1, font 8'h00.
  - Cell (col 2, row 2), i_y=46, frame_cnt[3]=0: o_fg=1.
  - Same cell at i_y=45: o_fg=0.
  - frame_cnt[3]=1: o_fg=0.
  - Cursor over a blink-hidden char in its visible phase: o_fg=1.
- Blanking and timing: i_de=0 with font 8'hFF -> o_attr=0, o_fg=0. An i_hsync/i_vsync pulse appears on o_hsync/o_vsync exactly 3 cycles later with the same width.
- Out-of-range row: i_y=480 (row 30), i_de=1 -> o_attr=0, o_fg=0. Frame counter wraps from 31 to 0 on the 32nd vsync rising edge.
